// File: rtl/seven_seg_scan.sv
// Multiplexed 7-segment driver: scans NUM_DIGITS active-low digits and
// swaps newly loaded data in only on frame boundaries, so a frame never tears.
module seven_seg_scan #(
  parameter int NUM_DIGITS      = 8,
  parameter int REFRESH_DIV     = 100000,
  parameter int LEAD_ZERO_BLANK = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("seven_seg_scan: NUM_DIGITS must be in 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $error("seven_seg_scan: REFRESH_DIV must be >= 2");
    end
    if (LEAD_ZERO_BLANK != 0 && LEAD_ZERO_BLANK != 1) begin : g_bad_lzb
      $error("seven_seg_scan: LEAD_ZERO_BLANK must be 0 or 1");
    end
  endgenerate

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic                    digit_tick;
  logic                    frame_edge;

  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  logic [NUM_DIGITS-1:0]   zero_blank;
  logic                    suppress;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_dark;
  logic [NUM_DIGITS-1:0]   an_next;

  assign digit_tick = (presc == PRESC_LAST);
  assign frame_edge = digit_tick && (idx == IDX_LAST);
  assign frame_tick = frame_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (digit_tick) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // On a load coinciding with a frame edge, the older pending value moves to
  // active while the new data lands in pending, which stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (frame_edge && pend_valid) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_valid <= 1'b1;
      end else if (frame_edge) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Leading-zero suppression walks down from the top digit; a lit dp or a
  // nonzero nibble ends it, and digit 0 is always shown.
  always_comb begin
    zero_blank = '0;
    suppress   = (LEAD_ZERO_BLANK != 0);
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (suppress && act_data[4*k +: 4] == 4'h0 && !act_dp[k]) begin
        zero_blank[k] = 1'b1;
      end else begin
        suppress = 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    an_next  = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib    = act_data[4*k +: 4];
        cur_dp     = act_dp[k];
        cur_dark   = act_blank[k] | zero_blank[k];
        an_next[k] = cur_dark;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      an  <= an_next;
      seg <= cur_dark ? 7'h7F : hex7(cur_nib);
      dp  <= cur_dark ? 1'b1 : ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with 4 digits and a 4-cycle refresh;
// a second instance has leading-zero blanking enabled.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;

  logic [6:0]  seg_a, seg_z;
  logic        dp_a, dp_z;
  logic [3:0]  an_a, an_z;
  logic        ft_a, ft_z;

  bit use_lz = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .LEAD_ZERO_BLANK(0)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(ft_a)
  );

  seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .LEAD_ZERO_BLANK(1)) dut_lz (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg_z), .dp(dp_z), .an(an_z), .frame_tick(ft_z)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                         input logic dp_e, input logic ft_e);
    chk({tag, ".an"},  {4'h0, use_lz ? an_z : an_a},   {4'h0, an_e});
    chk({tag, ".seg"}, {1'b0, use_lz ? seg_z : seg_a}, {1'b0, seg_e});
    chk({tag, ".dp"},  {7'h0, use_lz ? dp_z : dp_a},   {7'h0, dp_e});
    chk({tag, ".ft"},  {7'h0, use_lz ? ft_z : ft_a},   {7'h0, ft_e});
  endtask

  // Starts on a negedge; the display for digit 0 appears `lead` negedges
  // later and the task ends on the next frame_tick negedge.
  task automatic show_frame(input string tag, input int lead, input logic [27:0] segs,
                            input logic [3:0] dpo, input logic [3:0] dark,
                            input int ls1, input logic [15:0] d1, input logic [3:0] p1,
                            input logic [3:0] b1,
                            input int ls2, input logic [15:0] d2);
    int p;
    int k;
    for (int s = 1; s <= lead + 14; s++) begin
      @(negedge clk);
      load = 1'b0;
      p = s - lead;
      if (p >= 0) begin
        k = p / 4;
        if (dark[k])
          chk_all($sformatf("%s.d%0d.p%0d", tag, k, p), 4'hF, 7'h7F, 1'b1, p == 14);
        else
          chk_all($sformatf("%s.d%0d.p%0d", tag, k, p), ~(4'b0001 << k), segs[k*7 +: 7],
                  dpo[k], p == 14);
      end else begin
        chk({tag, ".ft_lead"}, {7'h0, use_lz ? ft_z : ft_a}, 8'h00);
      end
      if (s == ls1) begin
        load = 1'b1; data_in = d1; dp_in = p1; blank_in = b1;
      end
      if (s == ls2) begin
        load = 1'b1; data_in = d2; dp_in = 4'h0; blank_in = 4'h0;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    chk_all("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    use_lz = 1'b1;
    chk_all("reset_lz", 4'hF, 7'h7F, 1'b1, 1'b0);
    use_lz = 1'b0;
    rst = 1'b0;

    show_frame("idle", 1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0,
               -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
    show_frame("preload", 2, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0,
               5, 16'h12AF, 4'b0100, 4'h0, -1, 16'h0);
    show_frame("12AF", 2, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011, 4'h0,
               3, 16'h1111, 4'h0, 4'h0, 7, 16'h2222);
    show_frame("2222", 2, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'h0,
               5, 16'h4444, 4'h0, 4'h0, 16, 16'h5555);
    show_frame("4444", 2, {7'h19, 7'h19, 7'h19, 7'h19}, 4'hF, 4'h0,
               -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
    show_frame("5555", 2, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF, 4'h0,
               3, 16'h0050, 4'h0, 4'h0, -1, 16'h0);
    use_lz = 1'b1;
    show_frame("lz0050", 2, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 4'b1100,
               3, 16'h8888, 4'b0010, 4'b0010, -1, 16'h0);
    use_lz = 1'b0;
    show_frame("blank1", 2, {7'h00, 7'h00, 7'h00, 7'h00}, 4'hF, 4'b0010,
               -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

    for (int s = 1; s <= 6; s++) begin
      @(negedge clk);
      load = (s == 2);
      if (s == 2) begin
        data_in = 16'h7777; dp_in = 4'h0; blank_in = 4'h0;
      end
    end
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
    use_lz = 1'b1;
    chk_all("async_rst_lz", 4'hF, 7'h7F, 1'b1, 1'b0);
    use_lz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;

    show_frame("post_rst", 1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0,
               -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
    show_frame("no_pending", 2, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0,
               -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is driven, legal range >= 2.
REQ-003 SHALL have parameter LEAD_ZERO_BLANK, default 0, when 1 suppresses leading zero digits.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-005 Port list (clock and reset first):
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle strobe that captures data_in, dp_in and blank_in.
- data_in  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k.
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank_in  input  NUM_DIGITS  per-digit blank, 1 = digit dark.
- seg  output  7  segments {G,F,E,D,C,B,A}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  NUM_DIGITS  digit enables, active-low, at most one low.
- frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-006 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping; the terminal count is the digit tick.
REQ-007 SHALL advance a digit index 0..NUM_DIGITS-1 on each digit tick, wrapping from NUM_DIGITS-1 to 0.
REQ-008 SHALL define the frame boundary as the digit tick on which the index wraps to 0; frame_tick is high for exactly that cycle.
REQ-009 SHALL capture data_in, dp_in and blank_in into a pending register on any clock edge with load=1, and set pending_valid.
REQ-010 SHALL copy the pending register into the active register at a frame boundary only if pending_valid was set before that cycle, then clear pending_valid.
REQ-011 When load and a frame boundary occur in the same cycle:
- the older pending value transfers to the active register;
- the new data is written to the pending register;
- pending_valid stays 1.
REQ-012 Back-to-back loads within one frame: the last load wins; intermediate values are never displayed.
REQ-013 SHALL register seg, dp and an from the digit index and active register, one cycle after the index changes.
REQ-014 Hex decode, with lit segments per value:
- 0 ABCDEF, 1 BC, 2 ABDEG, 3 ABCDG
- 4 BCFG, 5 ACDFG, 6 ACDEFG, 7 ABC
- 8 ABCDEFG, 9 ABCDFG, A ABCEFG, b CDEFG
- C ADEF, d BCDEG, E ADEFG, F AEFG
REQ-015 For the current digit k, an[k]=0 and all other an bits are 1.
REQ-016 For a blanked digit k:
- an[k] SHALL be 1;
- seg SHALL be 7'h7F;
- dp SHALL be 1.
REQ-017 With LEAD_ZERO_BLANK=1, digits from NUM_DIGITS-1 downward whose nibble is 0 are blanked until the first nonzero nibble; digit 0 is never zero-blanked, and a lit dp on a digit stops suppression at that digit.
REQ-018 dp SHALL be the inverse of the active dp bit for the current digit, except when the digit is blanked.
REQ-019 Out-of-range parameters SHALL trigger an elaboration-time error.

Reset
REQ-020 While rst=1, the following SHALL hold regardless of clk:
- prescaler = 0, index = 0;
- active register = all zero, blank = 0, dp = 0;
- pending_valid = 0;
- an all 1s, seg = 7'h7F, dp = 1, frame_tick = 0.
REQ-021 After rst deasserts, the first digit tick SHALL occur REFRESH_DIV cycles later, with digit 0 driven showing "0" from the first clock edge.
REQ-022 A reset mid-frame or mid-load SHALL discard pending and active data.

Verification (bench uses NUM_DIGITS=4, REFRESH_DIV=4)
REQ-023 Reset then idle:
- an cycles 1110 -> 1101 -> 1011 -> 0111, each for 4 cycles;
- seg = 7'h40 ("0") throughout;
- frame_tick pulses every 16 cycles.
REQ-024 load with data_in=16'h12AF, dp_in=4'b0100, blank_in=0 mid-frame:
- no change before the next frame_tick;
- then digit0 seg=7'h0E (F), digit1 seg=7'h08 (A), digit2 seg=7'h24 (2) with dp=0, digit3 seg=7'h79 (1).
REQ-025 Two loads in one frame (16'h1111, then 16'h2222): only 2222 is ever displayed.
REQ-026 load coincident with frame_tick:
- the prior pending value displays this frame;
- the coincident value displays next frame.
REQ-027 LEAD_ZERO_BLANK=1 with data_in=16'h0050:
- digits 3 and 2 have an=1 and are dark;
- digit 1 shows 5, digit 0 shows 0.
REQ-028 blank_in=4'b0010:
- digit1 an stays 1 with seg=7'h7F and dp=1;
- rst asserted mid-frame forces all an to 1 immediately, asynchronously to clk.
